// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem_addr and fills the IF/ID register.
// Define FETCH_PERF_EN to add the fetch_count / bubble_count performance counters.
module fetch_stage #(
    parameter int                   A_WIDTH   = 32,
    parameter int                   D_WIDTH   = 32,
    parameter logic [A_WIDTH-1:0]   RESET_PC  = '0,
    parameter logic [D_WIDTH-1:0]   NOP_INSTR = D_WIDTH'(32'h0000_0013)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_F,
    input  logic               flush_D,
    input  logic               pc_src,
    input  logic [A_WIDTH-1:0] pc_target,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic [D_WIDTH-1:0] instr_D,
    output logic [A_WIDTH-1:0] pc_D,
    output logic [A_WIDTH-1:0] pc_plus4_D,
    output logic               valid_D,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
`endif
);

    localparam logic [D_WIDTH-1:0] EBREAK_INSTR = D_WIDTH'(32'h0010_0073);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [A_WIDTH-1:0] pc, pc_next, pc_inc;
    logic [D_WIDTH-1:0] instr_next;
    logic [A_WIDTH-1:0] pc_d_next, pc_plus4_d_next;
    logic               valid_next;
    logic               fetch_inc, bubble_inc;

    assign pc_inc    = pc + A_WIDTH'(4);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_next      = instr_D;
        pc_d_next       = pc_D;
        pc_plus4_d_next = pc_plus4_D;
        valid_next      = valid_D;
        fetch_inc       = 1'b0;
        bubble_inc      = 1'b0;

        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (pc_src) begin
                    // Redirect wins over stall; the instruction being fetched is wrong-path.
                    pc_next         = pc_target & ~A_WIDTH'(3);
                    instr_next      = NOP_INSTR;
                    pc_d_next       = '0;
                    pc_plus4_d_next = '0;
                    valid_next      = 1'b0;
                    bubble_inc      = 1'b1;
                end else if (flush_D) begin
                    if (!stall_F) begin
                        pc_next = pc_inc;
                    end
                    instr_next      = NOP_INSTR;
                    pc_d_next       = '0;
                    pc_plus4_d_next = '0;
                    valid_next      = 1'b0;
                    bubble_inc      = 1'b1;
                end else if (!stall_F) begin
                    instr_next      = imem_rdata;
                    pc_d_next       = pc;
                    pc_plus4_d_next = pc_inc;
                    valid_next      = 1'b1;
                    fetch_inc       = 1'b1;
                    if (imem_rdata == EBREAK_INSTR) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
            end
            HALT: begin
                instr_next      = NOP_INSTR;
                pc_d_next       = '0;
                pc_plus4_d_next = '0;
                valid_next      = 1'b0;
                bubble_inc      = 1'b1;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            instr_D    <= NOP_INSTR;
            pc_D       <= '0;
            pc_plus4_D <= '0;
            valid_D    <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_D    <= instr_next;
            pc_D       <= pc_d_next;
            pc_plus4_D <= pc_plus4_d_next;
            valid_D    <= valid_next;
        end
    end

`ifdef FETCH_PERF_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (fetch_inc && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bubble_inc && (bubble_count != '1)) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_inc | bubble_inc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a small combinational imem model.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        stall_F, flush_D, pc_src;
    logic [31:0] pc_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_D, pc_D, pc_plus4_D;
    logic        valid_D, halted;

    logic [31:0] mem [64];
    int nChecks = 0;
    int nFails  = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_F    (stall_F),
        .flush_D    (flush_D),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc_plus4_D (pc_plus4_D),
        .valid_D    (valid_D),
        .halted     (halted)
    );

    assign imem_rdata = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] target;
        logic [31:0] eAddr;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic [31:0] ePc4;
        logic        eValid;
        logic        eHalted;
        logic        chkPc;
    } vec_t;

    vec_t vecs [22];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic p, input logic [31:0] t);
        stall_F   = s;
        flush_D   = f;
        pc_src    = p;
        pc_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " addr"},   imem_addr,  32'h0);
        checkOutput({tag, " instr"},  instr_D,    NOP);
        checkOutput({tag, " pc_D"},   pc_D,       32'h0);
        checkOutput({tag, " pc4_D"},  pc_plus4_D, 32'h0);
        checkOutput({tag, " valid"},  32'(valid_D), 32'h0);
        checkOutput({tag, " halted"}, 32'(halted),  32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 2);
        mem[0]  = 32'h0050_0093;
        mem[12] = EBREAK;

        // stall flush pcsrc target | addr instr pc_D pc4_D valid halted chkPc
        vecs[0]  = '{0,0,0,32'h0,        32'h00,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[1]  = '{0,0,0,32'h0,        32'h04,       32'h0050_0093,32'h0,        32'h4,  1,0,1};
        vecs[2]  = '{0,0,0,32'h0,        32'h08,       32'hA000_0004,32'h4,        32'h8,  1,0,1};
        vecs[3]  = '{0,0,0,32'h0,        32'h0C,       32'hA000_0008,32'h8,        32'hC,  1,0,1};
        vecs[4]  = '{0,0,0,32'h0,        32'h10,       32'hA000_000C,32'hC,        32'h10, 1,0,1};
        vecs[5]  = '{0,0,1,32'h4,        32'h04,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[6]  = '{0,0,0,32'h0,        32'h08,       32'hA000_0004,32'h4,        32'h8,  1,0,1};
        vecs[7]  = '{1,0,0,32'h0,        32'h08,       32'hA000_0004,32'h4,        32'h8,  1,0,1};
        vecs[8]  = '{1,0,0,32'h0,        32'h08,       32'hA000_0004,32'h4,        32'h8,  1,0,1};
        vecs[9]  = '{1,0,1,32'h43,       32'h40,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[10] = '{0,0,1,32'h20,       32'h20,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[11] = '{0,1,0,32'h0,        32'h24,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[12] = '{1,1,0,32'h0,        32'h24,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[13] = '{0,0,0,32'h0,        32'h28,       32'hA000_0024,32'h24,       32'h28, 1,0,1};
        vecs[14] = '{0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,NOP,          32'h0,        32'h0,  0,0,0};
        vecs[15] = '{0,0,0,32'h0,        32'h00,       32'hA000_00FC,32'hFFFF_FFFC,32'h0,  1,0,1};
        vecs[16] = '{0,0,1,32'h28,       32'h28,       NOP,          32'h0,        32'h0,  0,0,0};
        vecs[17] = '{0,0,0,32'h0,        32'h2C,       32'hA000_0028,32'h28,       32'h2C, 1,0,1};
        vecs[18] = '{0,0,0,32'h0,        32'h30,       32'hA000_002C,32'h2C,       32'h30, 1,0,1};
        vecs[19] = '{0,0,0,32'h0,        32'h30,       EBREAK,       32'h30,       32'h34, 1,1,1};
        vecs[20] = '{0,1,1,32'h80,       32'h30,       NOP,          32'h0,        32'h0,  0,1,0};
        vecs[21] = '{0,0,0,32'h0,        32'h30,       NOP,          32'h0,        32'h0,  0,1,0};

        rst_n = 1'b0;
        stall_F = 1'b0; flush_D = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].pcsrc, vecs[i].target);
            checkOutput($sformatf("v%0d addr", i),   imem_addr,        vecs[i].eAddr);
            checkOutput($sformatf("v%0d instr", i),  instr_D,          vecs[i].eInstr);
            checkOutput($sformatf("v%0d valid", i),  32'(valid_D),     32'(vecs[i].eValid));
            checkOutput($sformatf("v%0d halted", i), 32'(halted),      32'(vecs[i].eHalted));
            if (vecs[i].chkPc) begin
                checkOutput($sformatf("v%0d pc_D", i),  pc_D,       vecs[i].ePc);
                checkOutput($sformatf("v%0d pc4_D", i), pc_plus4_D, vecs[i].ePc4);
            end
        end

        // Asynchronous reset while halted clears halted before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("haltReset");
        stall_F = 1'b0; flush_D = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // EBREAK fetched on the same edge as a redirect must not halt.
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("boot2 addr", imem_addr, 32'h0);
        applyStimulus(0, 0, 1, 32'h30);
        checkOutput("toEbreak addr", imem_addr, 32'h30);
        applyStimulus(0, 0, 1, 32'h50);
        checkOutput("ebreakRedirect addr",   imem_addr,     32'h50);
        checkOutput("ebreakRedirect halted", 32'(halted),   32'h0);
        checkOutput("ebreakRedirect valid",  32'(valid_D),  32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("afterRedirect instr",  instr_D,       32'hA000_0050);
        checkOutput("afterRedirect pc_D",   pc_D,          32'h50);
        checkOutput("afterRedirect valid",  32'(valid_D),  32'h1);
        checkOutput("afterRedirect halted", 32'(halted),   32'h0);
        checkOutput("afterRedirect addr",   imem_addr,     32'h54);

        // Asynchronous reset mid-run with PC at 0x1C.
        applyStimulus(0, 0, 1, 32'h18);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("preReset addr",  imem_addr,    32'h1C);
        checkOutput("preReset valid", 32'(valid_D), 32'h1);
        checkOutput("preReset instr", instr_D,      32'hA000_0018);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("asyncReset");
        @(posedge clk);
        #1;
        checkResetValues("heldReset");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the execute datapath.
- Owns the program counter and drives the instruction-memory address.
- Registers each fetched instruction, its PC and PC+4 into an IF/ID pipeline register for the decode/control logic, which produces the rs1/rs2/rd/ImmOp fields consumed downstream.
- Handles stall, flush, branch/jump redirect and halt on EBREAK.

Parameters:
- A_WIDTH, 32, PC / instruction-memory address width in bits.
- D_WIDTH, 32, instruction width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall_F  input  1  hold PC and IF/ID register this cycle.
- flush_D  input  1  replace IF/ID contents with a bubble at the next edge.
- pc_src  input  1  redirect request (taken branch/jump).
- pc_target  input  A_WIDTH  redirect target address.
- imem_addr  output  A_WIDTH  instruction-memory address; equals current PC.
- imem_rdata  input  D_WIDTH  instruction word; combinational read of imem_addr.
- instr_D  output  D_WIDTH  registered instruction to decode.
- pc_D  output  A_WIDTH  registered PC of instr_D.
- pc_plus4_D  output  A_WIDTH  registered pc_D+4.
- valid_D  output  1  instr_D is a real instruction, not a bubble.
- halted  output  1  EBREAK fetched; fetch stopped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- While rst_n=0:
  - PC=RESET_PC, instr_D=NOP_INSTR, pc_D=0, pc_plus4_D=0, valid_D=0, halted=0, state=BOOT.
- State machine (3 states):
  - BOOT: first edge after reset release; IF/ID stays bubble; PC unchanged. -> RUN.
  - RUN: normal fetch.
  - HALT: PC frozen; IF/ID loads bubbles; halted=1. Exit only via reset.
- RUN priority per edge, highest first:
  1. pc_src=1: PC<=pc_target with bits[1:0] forced to 00; IF/ID<=bubble (wrong-path instruction discarded). Overrides stall_F.
  2. flush_D=1 (without pc_src): IF/ID<=bubble. PC advances unless stall_F=1.
  3. stall_F=1: PC and IF/ID hold all values, including valid_D.
  4. Otherwise: PC<=PC+4 (wraps modulo 2^A_WIDTH); IF/ID<={imem_rdata, PC, PC+4}; valid_D<=1.
- EBREAK: if case 4 captures imem_rdata==32'h0010_0073:
  - it is still latched with valid_D=1;
  - state->HALT at the same edge; PC holds.
  - A simultaneous pc_src suppresses the halt, since the instruction is wrong-path.
- Latency: instruction at PC p appears on instr_D exactly one edge after imem_addr=p (no stall).
- imem_addr is combinational from the PC register; no other combinational path from inputs to registered outputs.
- Arithmetic: PC+4 is unsigned, A_WIDTH wide, with carry discarded.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs and two counters:
  - fetch_count (32 bits): increments on every case-4 load.
  - bubble_count (32 bits): increments on every edge in RUN/HALT where valid_D is loaded 0.
  - Both reset to 0 and saturate at all-ones.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/boot: hold rst_n=0 3 cycles, release; imem returns 32'h0050_0093 at 0x0 -> edge1 still bubble (BOOT); edge2 instr_D=32'h0050_0093, pc_D=0, pc_plus4_D=4, valid_D=1; imem_addr=4.
- Sequential fetch: 4 free-running edges from 0x0 -> pc_D sequence 0,4,8,C; imem_addr=0x10.
- Stall vs redirect: at PC=0x8, stall_F=1 for 2 edges -> PC and instr_D held; then stall_F=1 with pc_src=1, pc_target=0x43 -> PC=0x40, valid_D=0.
- Flush: flush_D=1 at PC=0x20 -> valid_D=0, instr_D=NOP_INSTR, PC=0x24.
- EBREAK: imem returns 32'h0010_0073 at 0x30 -> instr_D=EBREAK, valid_D=1, halted=1, PC stays 0x30, following valid_D=0. Repeat with pc_src=1 on the same edge -> no halt, PC=target.
- Async reset mid-run: drop rst_n between edges at PC=0x1C -> outputs return to reset values immediately, without waiting for a clock edge.
